// File: rtl/wshb_arbiter_2_if.sv
// Wishbone bus bundle shared by the arbiter ports; the master modport drives a
// transaction, the slave modport answers it.
interface wshb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output cyc, stb, we, adr, sel, dat_ms,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_ms,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_arbiter_2.sv
// Two-port Wishbone arbiter: one master owns the shared slave for the whole of
// its cyc, ownership passes round-robin or with fixed port-0 priority.
module wshb_arbiter_2 #(
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic       clk,
   input  logic       rst,
   wshb_if.slave      wshb_ifs_0,
   wshb_if.slave      wshb_ifs_1,
   wshb_if.master     wshb_ifm,
   output logic [1:0] grant
);

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_P0   = 2'd1,
      OWNER_P1   = 2'd2
   } owner_t;

   owner_t owner_q, owner_d;
   logic   last_q, last_d;   // 0 = port 0 served last, 1 = port 1
   logic   rearb;

   always_comb begin
      owner_d = owner_q;
      last_d  = last_q;
      case (owner_q)
         OWNER_P0: rearb = !wshb_ifs_0.cyc;
         OWNER_P1: rearb = !wshb_ifs_1.cyc;
         default:  rearb = 1'b1;
      endcase
      // A releasing owner has cyc low, so it drops out of the candidates by itself.
      if (rearb) begin
         if (wshb_ifs_0.cyc && wshb_ifs_1.cyc) begin
            if ((ROUND_ROBIN != 0) && !last_q) owner_d = OWNER_P1;
            else                               owner_d = OWNER_P0;
         end else if (wshb_ifs_0.cyc) begin
            owner_d = OWNER_P0;
         end else if (wshb_ifs_1.cyc) begin
            owner_d = OWNER_P1;
         end else begin
            owner_d = OWNER_NONE;
         end
         if (owner_d == OWNER_P0) last_d = 1'b0;
         if (owner_d == OWNER_P1) last_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWNER_NONE;
         last_q  <= 1'b1;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
   assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;

   always_comb begin
      grant           = 2'b00;
      wshb_ifm.cyc    = 1'b0;
      wshb_ifm.stb    = 1'b0;
      wshb_ifm.we     = 1'b0;
      wshb_ifm.adr    = '0;
      wshb_ifm.sel    = '0;
      wshb_ifm.dat_ms = '0;
      wshb_ifs_0.ack  = 1'b0;
      wshb_ifs_0.err  = 1'b0;
      wshb_ifs_0.rty  = 1'b0;
      wshb_ifs_1.ack  = 1'b0;
      wshb_ifs_1.err  = 1'b0;
      wshb_ifs_1.rty  = 1'b0;
      case (owner_q)
         OWNER_P0: begin
            grant           = 2'b01;
            wshb_ifm.cyc    = wshb_ifs_0.cyc;
            wshb_ifm.stb    = wshb_ifs_0.stb;
            wshb_ifm.we     = wshb_ifs_0.we;
            wshb_ifm.adr    = wshb_ifs_0.adr;
            wshb_ifm.sel    = wshb_ifs_0.sel;
            wshb_ifm.dat_ms = wshb_ifs_0.dat_ms;
            wshb_ifs_0.ack  = wshb_ifm.ack;
            wshb_ifs_0.err  = wshb_ifm.err;
            wshb_ifs_0.rty  = wshb_ifm.rty;
         end
         OWNER_P1: begin
            grant           = 2'b10;
            wshb_ifm.cyc    = wshb_ifs_1.cyc;
            wshb_ifm.stb    = wshb_ifs_1.stb;
            wshb_ifm.we     = wshb_ifs_1.we;
            wshb_ifm.adr    = wshb_ifs_1.adr;
            wshb_ifm.sel    = wshb_ifs_1.sel;
            wshb_ifm.dat_ms = wshb_ifs_1.dat_ms;
            wshb_ifs_1.ack  = wshb_ifm.ack;
            wshb_ifs_1.err  = wshb_ifm.err;
            wshb_ifs_1.rty  = wshb_ifm.rty;
         end
         default: ;
      endcase
   end

endmodule
